// File: rtl/mux_2to1_if.sv
// Signal bundle for the two-input selector: data sources and select in,
// combinational/registered selection and select-change pulse out.
interface mux_2to1_if #(
  parameter int WIDTH = 1
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sel;
  logic [WIDTH-1:0] f;
  logic [WIDTH-1:0] f_q;
  logic             sel_chg;

  modport master (
    output a, b, sel,
    input  f, f_q, sel_chg
  );

  modport slave (
    input  a, b, sel,
    output f, f_q, sel_chg
  );
endinterface

// File: rtl/mux_2to1.sv
// Two-input selector with a registered copy of the selection and a
// one-cycle pulse flagging every sampled change of the select line.
module mux_2to1 #(
  parameter int WIDTH = 1
) (
  input  logic        clk,
  input  logic        rst,
  mux_2to1_if.slave   bus
);

  logic [WIDTH-1:0] f_sel;
  logic [WIDTH-1:0] f_q;
  logic             sel_q;
  logic             sel_chg;

  // An unknown select falls through to the else branch, matching the
  // synthesis view where only sel=1 picks b.
  always_comb begin
    f_sel = bus.a;
    if (bus.sel == 1'b1) begin
      f_sel = bus.b;
    end
  end

  // ---- registered stage ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f_q     <= '0;
      sel_q   <= 1'b0;
      sel_chg <= 1'b0;
    end else begin
      f_q     <= f_sel;
      sel_q   <= bus.sel;
      sel_chg <= (bus.sel != sel_q);
    end
  end

  assign bus.f       = f_sel;
  assign bus.f_q     = f_q;
  assign bus.sel_chg = sel_chg;

endmodule

// File: tb/tb_mux_2to1.sv
// Directed bench for mux_2to1: combinational truth table (clock running and
// stopped), registered path, select-change pulse, reset behaviour, wide data.
module tb_mux_2to1;

  logic clk;
  logic clk_en;
  logic rst;
  int   errors;
  int   checks;

  mux_2to1_if #(.WIDTH(1)) bus1 ();
  mux_2to1_if #(.WIDTH(8)) bus8 ();

  mux_2to1 #(.WIDTH(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1.slave)
  );

  mux_2to1 #(.WIDTH(8)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8.slave)
  );

  initial clk = 1'b0;
  always #5 if (clk_en) clk = ~clk;

  typedef struct {
    logic sel;
    logic a;
    logic b;
    logic f;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic run_table(input string tag);
    for (int i = 0; i < 8; i++) begin
      bus1.sel = vecs[i].sel;
      bus1.a   = vecs[i].a;
      bus1.b   = vecs[i].b;
      #5;
      check($sformatf("%s f vec%0d", tag, i), 64'(bus1.f), 64'(vecs[i].f));
      #5;
    end
  endtask

  logic pat_sel [6];
  logic pat_chg [6];

  initial begin
    errors = 0;
    checks = 0;
    clk_en = 1'b1;
    rst    = 1'b1;
    bus1.a = 1'b0; bus1.b = 1'b0; bus1.sel = 1'b0;
    bus8.a = 8'h00; bus8.b = 8'h00; bus8.sel = 1'b0;

    vecs[0] = '{sel: 1'b0, a: 1'b0, b: 1'b0, f: 1'b0};
    vecs[1] = '{sel: 1'b0, a: 1'b1, b: 1'b0, f: 1'b1};
    vecs[2] = '{sel: 1'b0, a: 1'b0, b: 1'b1, f: 1'b0};
    vecs[3] = '{sel: 1'b0, a: 1'b1, b: 1'b1, f: 1'b1};
    vecs[4] = '{sel: 1'b1, a: 1'b0, b: 1'b0, f: 1'b0};
    vecs[5] = '{sel: 1'b1, a: 1'b1, b: 1'b0, f: 1'b0};
    vecs[6] = '{sel: 1'b1, a: 1'b0, b: 1'b1, f: 1'b1};
    vecs[7] = '{sel: 1'b1, a: 1'b1, b: 1'b1, f: 1'b1};

    pat_sel = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    pat_chg = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    // Reset state, before any clock edge
    #3;
    check("rst f_q w1", 64'(bus1.f_q), 64'h0);
    check("rst sel_chg w1", 64'(bus1.sel_chg), 64'h0);
    check("rst f_q w8", 64'(bus8.f_q), 64'h0);
    check("rst sel_chg w8", 64'(bus8.sel_chg), 64'h0);

    @(negedge clk);
    rst = 1'b0;

    run_table("clk_on");

    @(negedge clk);
    clk_en = 1'b0;
    run_table("clk_off");
    clk_en = 1'b1;

    // Registered path
    @(negedge clk);
    bus1.sel = 1'b0; bus1.a = 1'b0; bus1.b = 1'b0;
    @(negedge clk);
    bus1.sel = 1'b1; bus1.b = 1'b1; bus1.a = 1'b0;
    #1;
    check("reg f comb", 64'(bus1.f), 64'h1);
    check("reg f_q before edge", 64'(bus1.f_q), 64'h0);
    @(posedge clk); #1;
    check("reg f_q after edge", 64'(bus1.f_q), 64'h1);
    check("reg sel_chg 0->1", 64'(bus1.sel_chg), 64'h1);

    // Select-change pulse: settle on 0, then 0,0,0,1,1,1
    @(negedge clk);
    bus1.sel = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      bus1.sel = pat_sel[i];
      @(posedge clk); #1;
      check($sformatf("pulse cyc%0d", i), 64'(bus1.sel_chg), 64'(pat_chg[i]));
      @(negedge clk);
    end

    // Reset mid-operation (sel_q is 1 here)
    bus1.sel = 1'b0; bus1.a = 1'b1; bus1.b = 1'b0;
    @(posedge clk); #1;
    check("mid pre f_q", 64'(bus1.f_q), 64'h1);
    check("mid pre sel_chg", 64'(bus1.sel_chg), 64'h1);
    #2;
    rst = 1'b1;
    #1;
    check("mid rst f_q", 64'(bus1.f_q), 64'h0);
    check("mid rst sel_chg", 64'(bus1.sel_chg), 64'h0);
    bus1.a = 1'b0; #1;
    check("mid rst f follows 0", 64'(bus1.f), 64'h0);
    bus1.a = 1'b1; #1;
    check("mid rst f follows 1", 64'(bus1.f), 64'h1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("release f_q reload", 64'(bus1.f_q), 64'h1);
    check("release sel0 no chg", 64'(bus1.sel_chg), 64'h0);

    // Release with first sampled sel=1 reports a change
    @(negedge clk);
    rst = 1'b1;
    bus1.sel = 1'b1; bus1.b = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("release sel1 chg", 64'(bus1.sel_chg), 64'h1);
    check("release sel1 f_q", 64'(bus1.f_q), 64'h1);

    // Wide instance
    @(negedge clk);
    bus8.a = 8'hA5; bus8.b = 8'h3C; bus8.sel = 1'b0;
    #1;
    check("w8 f sel0", 64'(bus8.f), 64'hA5);
    @(posedge clk); #1;
    check("w8 f_q sel0", 64'(bus8.f_q), 64'hA5);
    @(negedge clk);
    bus8.sel = 1'b1;
    #1;
    check("w8 f sel1", 64'(bus8.f), 64'h3C);
    check("w8 f_q held", 64'(bus8.f_q), 64'hA5);
    @(posedge clk); #1;
    check("w8 f_q sel1", 64'(bus8.f_q), 64'h3C);
    check("w8 sel_chg", 64'(bus8.sel_chg), 64'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
